// File: rtl/mult_6x6_seq.sv
// Sequential 6x6 unsigned multiplier built around a single time-shared
// 3x3 combinational multiplier; one result every six cycles at best.
`timescale 1ns/1ps

module mult_3x3 (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] p
);
    assign p = {3'b000, a} * {3'b000, b};
endmodule

module mult_6x6_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    output logic        busy,
    output logic        done,
    output logic [11:0] product
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  step;
    logic [5:0]  a_r, b_r;
    logic [11:0] acc;
    logic [2:0]  ma, mb;
    logic [5:0]  pp;
    logic [11:0] pp_sh, sum;

    mult_3x3 u_mul (
        .a (ma),
        .b (mb),
        .p (pp)
    );

    // step[0] picks the high half of a_r, step[1] the high half of b_r
    always_comb begin
        ma    = step[0] ? a_r[5:3] : a_r[2:0];
        mb    = step[1] ? b_r[5:3] : b_r[2:0];
        pp_sh = '0;
        case (step)
            2'd0:    pp_sh = {6'b000000, pp};
            2'd1,
            2'd2:    pp_sh = {3'b000, pp, 3'b000};
            default: pp_sh = {pp, 6'b000000};
        endcase
        sum = acc + pp_sh;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (step == 2'd3) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            step    <= '0;
            acc     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        acc  <= '0;
                        step <= '0;
                    end
                end
                CALC: begin
                    acc  <= sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) product <= sum;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_mult_6x6_seq.sv
// Directed self-checking bench for mult_6x6_seq: reset, latency, ignored
// starts, input stability, mid-operation reset, back-to-back and all pairs.
`timescale 1ns/1ps

module tb_mult_6x6_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        busy;
    logic        done;
    logic [11:0] product;

    int n_checks = 0;
    int n_errors = 0;

    mult_6x6_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] va(input int c);
        va = 6'((c * 7 + 3) % 64);
    endfunction

    function automatic logic [5:0] vb(input int c);
        vb = 6'((c * 11 + 5) % 64);
    endfunction

    // Bounded wait for the done pulse, then check the product.
    task automatic wait_done(input string tag, input logic [11:0] exp);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (!found) begin
                if (done) begin
                    found = 1'b1;
                    check(tag, 32'(product), 32'(exp));
                end else begin
                    @(negedge clk);
                end
            end
        end
        if (!found) check({tag, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic run_op(input string tag, input logic [5:0] ta, input logic [5:0] tb_,
                          input logic [11:0] exp, input logic full);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        @(negedge clk);
        start = 1'b0;
        if (full) begin
            for (int n = 0; n < 5; n++) begin
                check({tag, "_busy"}, 32'(busy), 32'(1));
                check({tag, "_done"}, 32'(done), 32'(n == 4));
                if (n == 4) check({tag, "_product"}, 32'(product), 32'(exp));
                @(negedge clk);
            end
            check({tag, "_busy_end"}, 32'(busy), 32'(0));
            check({tag, "_done_end"}, 32'(done), 32'(0));
            check({tag, "_hold"}, 32'(product), 32'(exp));
        end else begin
            wait_done(tag, exp);
        end
    endtask

    initial begin
        logic seen;
        rst   = 1'b1;
        start = 1'b1;
        a     = 6'd5;
        b     = 6'd7;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_product", 32'(product), 32'(0));
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset_prio_busy", 32'(busy), 32'(0));

        run_op("op_5x7", 6'd5, 6'd7, 12'd35, 1'b1);
        run_op("op_63x63", 6'd63, 6'd63, 12'd3969, 1'b1);
        run_op("op_0x45", 6'd0, 6'd45, 12'd0, 1'b1);
        run_op("op_45x38", 6'd45, 6'd38, 12'd1710, 1'b1);

        // start pulses while busy (CALC and DONE) must be ignored
        @(negedge clk);
        start = 1'b1; a = 6'd9; b = 6'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 6'd2; b = 6'd2;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy", 32'(busy), 32'(1));
        @(negedge clk);
        @(negedge clk);
        check("ign_done", 32'(done), 32'(1));
        check("ign_product", 32'(product), 32'(81));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_idle", 32'(busy), 32'(0));
        @(negedge clk);
        check("ign_no_restart", 32'(busy), 32'(0));
        check("ign_hold", 32'(product), 32'(81));

        // inputs changed after acceptance
        @(negedge clk);
        start = 1'b1; a = 6'd20; b = 6'd30;
        @(negedge clk);
        start = 1'b0; a = 6'd1; b = 6'd1;
        wait_done("stable_inputs", 12'd600);

        // reset during CALC aborts the operation
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 6'd20; b = 6'd30;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_product", 32'(product), 32'(0));
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_pulse", 32'(seen), 32'(0));
        run_op("after_abort", 6'd3, 6'd4, 12'd12, 1'b1);

        // start held high: accepts at edges 0,6,12,18
        @(negedge clk);
        start = 1'b1;
        a = va(0);
        b = vb(0);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            check("b2b_done", 32'(done), 32'((c % 6) == 4));
            if ((c % 6) == 4)
                check("b2b_product", 32'(product), 32'(int'(va(c - 4)) * int'(vb(c - 4))));
            a = va(c + 1);
            b = vb(c + 1);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 4096; i++) begin
            logic [11:0] iv;
            iv = 12'(i);
            run_op("all_pairs", iv[11:6], iv[5:0], 12'(int'(iv[11:6]) * int'(iv[5:0])), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
